// File: rtl/fft_power_avg_pkg.sv
// ---------------------------------------------------------------------------
// fft_power_avg_pkg
//   Shared types and default widths for the FFT power-averaging stage.
//   - state_t      : control FSM encoding, also driven out on o_dbg_state
//   - FFT_IWIDTH   : bits per real/imag component produced by the FFT
//   - FFT_LGSIZE   : log2 of the FFT length
//   - FFT_OWIDTH   : width of the averaged power word handed to readout
// ---------------------------------------------------------------------------
package fft_power_avg_pkg;

  localparam int FFT_IWIDTH = 16;
  localparam int FFT_LGSIZE = 11;
  localparam int FFT_OWIDTH = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/fft_power_ram.sv
// ---------------------------------------------------------------------------
// fft_power_ram
//   Simple dual-port accumulator RAM, one write port and one read port with a
//   registered read (block-RAM friendly). Contents are never reset; the
//   caller never uses a word before it has been written in the current
//   averaging period.
//   Ports:
//     i_clk      clock
//     wr_en_i    write strobe
//     wr_addr_i  write address
//     wr_data_i  write data
//     rd_addr_i  read address, sampled every clock
//     rd_data_o  read data, one clock after rd_addr_i
// ---------------------------------------------------------------------------
module fft_power_ram #(
  parameter int AWIDTH = 11,
  parameter int DWIDTH = 36
) (
  input  logic              i_clk,
  input  logic              wr_en_i,
  input  logic [AWIDTH-1:0] wr_addr_i,
  input  logic [DWIDTH-1:0] wr_data_i,
  input  logic [AWIDTH-1:0] rd_addr_i,
  output logic [DWIDTH-1:0] rd_data_o
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  always_ff @(posedge i_clk) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
    rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/fft_power_avg.sv
// ---------------------------------------------------------------------------
// fft_power_avg
//   Per-bin power (re^2 + im^2) of the FFT output stream, averaged over
//   2^LGAVG consecutive frames. One averaged spectrum is streamed out per
//   averaging period, with bin-0 and last-bin markers.
//
//   Handshake: i_ce qualifies i_sync/i_sample on a clock edge; there is no
//   backpressure. o_valid is a single-cycle strobe qualifying o_data,
//   o_sync and o_last; there is no ready. o_resync is an independent pulse.
//
//   Ports:
//     i_clk, i_reset  clock, synchronous active-high reset
//     i_ce            input sample valid
//     i_sync          with i_ce, marks bin 0 of an FFT frame
//     i_sample        {re, im}, two's complement
//     o_valid         averaged power word valid
//     o_data          averaged power, saturated to OWIDTH
//     o_sync, o_last  with o_valid, first / last bin of the spectrum
//     o_resync        pulse when i_sync arrives mid-frame
//     o_dbg_state     current control state
//
//   Pipeline (advances every clock, fixed 3-edge latency):
//     E0 accept: square re/im, read RAM[bin]
//     E1        : sum squares -> P, capture old accumulator (or 0 in frame 0)
//     E2        : old + P, write back, register outputs
// ---------------------------------------------------------------------------
module fft_power_avg
  import fft_power_avg_pkg::*;
#(
  parameter int IWIDTH = FFT_IWIDTH,
  parameter int LGSIZE = FFT_LGSIZE,
  parameter int LGAVG  = 3,
  parameter int OWIDTH = FFT_OWIDTH
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_ce,
  input  logic                i_sync,
  input  logic [2*IWIDTH-1:0] i_sample,
  output logic                o_valid,
  output logic [OWIDTH-1:0]   o_data,
  output logic                o_sync,
  output logic                o_last,
  output logic                o_resync,
  output state_t              o_dbg_state
);

  localparam int PW = 2*IWIDTH + 1;              // exact power width
  localparam int AW = PW + LGAVG;                // accumulator width
  localparam int FW = (LGAVG > 0) ? LGAVG : 1;   // frame counter width
  localparam logic [LGSIZE-1:0] BIN_MAX    = '1;
  localparam logic [FW-1:0]     FRAME_LAST = FW'((2**LGAVG) - 1);

  state_t            state_q;
  logic [LGSIZE-1:0] bin_q;
  logic [FW-1:0]     frame_q;

  // Stage 1 (after E0)
  logic                       s1_valid_q;
  logic [LGSIZE-1:0]          s1_bin_q;
  logic                       s1_first_q;
  logic                       s1_emit_q;
  logic signed [2*IWIDTH-1:0] re_sq_q;
  logic signed [2*IWIDTH-1:0] im_sq_q;

  // Stage 2 (after E1)
  logic              s2_valid_q;
  logic [LGSIZE-1:0] s2_bin_q;
  logic              s2_emit_q;
  logic [AW-1:0]     s2_old_q;
  logic [PW-1:0]     s2_pwr_q;

  // Input decode
  logic signed [IWIDTH-1:0]   re_d;
  logic signed [IWIDTH-1:0]   im_d;
  logic signed [2*IWIDTH-1:0] re_sq_d;
  logic signed [2*IWIDTH-1:0] im_sq_d;
  logic                       accept_d;
  logic                       restart_d;
  logic                       resync_d;
  logic [LGSIZE-1:0]          cur_bin_d;
  logic [FW-1:0]              cur_frame_d;
  logic                       last_frame_d;
  logic [LGSIZE-1:0]          bin_d;
  logic [FW-1:0]              frame_d;

  logic [AW-1:0]     ram_rd_data;
  logic [PW-1:0]     pwr_d;
  logic [AW-1:0]     sum_d;
  logic [AW-1:0]     shifted_d;
  logic [OWIDTH-1:0] sat_d;

  always_comb begin
    re_d     = i_sample[2*IWIDTH-1:IWIDTH];
    im_d     = i_sample[IWIDTH-1:0];
    re_sq_d  = re_d * re_d;
    im_sq_d  = im_d * im_d;
    // Samples before the first sync are dropped.
    accept_d = i_ce && ((state_q == ST_ACCUM) || i_sync);
    // A sync from IDLE, or one arriving at a nonzero bin, restarts the
    // averaging period. A sync at bin 0 just agrees with the counters.
    restart_d    = i_sync && ((state_q == ST_IDLE) || (bin_q != '0));
    resync_d     = accept_d && i_sync && (state_q == ST_ACCUM) && (bin_q != '0);
    cur_bin_d    = restart_d ? '0 : bin_q;
    cur_frame_d  = restart_d ? '0 : frame_q;
    last_frame_d = (cur_frame_d == FRAME_LAST);
    bin_d        = cur_bin_d + 1'b1;
    frame_d      = cur_frame_d;
    if (cur_bin_d == BIN_MAX) begin
      frame_d = last_frame_d ? '0 : cur_frame_d + 1'b1;
    end
  end

  // Squares are non-negative, so zero extension is exact.
  assign pwr_d     = PW'($unsigned(re_sq_q)) + PW'($unsigned(im_sq_q));
  assign sum_d     = s2_old_q + AW'(s2_pwr_q);
  assign shifted_d = sum_d >> LGAVG;

  generate
    if (OWIDTH >= AW) begin : g_no_sat
      assign sat_d = OWIDTH'(shifted_d);
    end else begin : g_sat
      assign sat_d = (|shifted_d[AW-1:OWIDTH]) ? '1 : shifted_d[OWIDTH-1:0];
    end
  endgenerate

  fft_power_ram #(
    .AWIDTH (LGSIZE),
    .DWIDTH (AW)
  ) u_ram (
    .i_clk     (i_clk),
    .wr_en_i   (s2_valid_q),
    .wr_addr_i (s2_bin_q),
    .wr_data_i (sum_d),
    .rd_addr_i (cur_bin_d),
    .rd_data_o (ram_rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      frame_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_bin_q   <= '0;
      s1_first_q <= 1'b0;
      s1_emit_q  <= 1'b0;
      re_sq_q    <= '0;
      im_sq_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_bin_q   <= '0;
      s2_emit_q  <= 1'b0;
      s2_old_q   <= '0;
      s2_pwr_q   <= '0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_sync     <= 1'b0;
      o_last     <= 1'b0;
      o_resync   <= 1'b0;
    end else begin
      // Control FSM and counters, E0
      if (accept_d) begin
        state_q <= ST_ACCUM;
        bin_q   <= bin_d;
        frame_q <= frame_d;
      end
      o_resync <= resync_d;

      // Stage 1
      s1_valid_q <= accept_d;
      s1_bin_q   <= cur_bin_d;
      s1_first_q <= (cur_frame_d == '0);
      s1_emit_q  <= last_frame_d;
      re_sq_q    <= re_sq_d;
      im_sq_q    <= im_sq_d;

      // Stage 2: first frame of a period ignores whatever the RAM held.
      s2_valid_q <= s1_valid_q;
      s2_bin_q   <= s1_bin_q;
      s2_emit_q  <= s1_emit_q;
      s2_old_q   <= s1_first_q ? '0 : ram_rd_data;
      s2_pwr_q   <= pwr_d;

      // Output stage
      o_valid <= s2_valid_q && s2_emit_q;
      o_data  <= sat_d;
      o_sync  <= s2_valid_q && s2_emit_q && (s2_bin_q == '0);
      o_last  <= s2_valid_q && s2_emit_q && (s2_bin_q == BIN_MAX);
    end
  end

  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_fft_power_avg.sv
// ---------------------------------------------------------------------------
// tb_fft_power_avg
//   Two instances share the input stream: dut_a (8 bins, 2-frame average,
//   32-bit output) and dut_b (8 bins, no averaging, 31-bit output, only
//   enabled for the saturation vectors). Expected words are queued before
//   each vector set is driven; a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_fft_power_avg;
  import fft_power_avg_pkg::*;

  localparam int IW   = 16;
  localparam int OW_A = 32;
  localparam int OW_B = 31;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_reset;
  logic i_ce;
  logic i_sync;
  logic ce_b_en;
  logic [2*IW-1:0] i_sample;

  always #5 i_clk = ~i_clk;

  int unsigned cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  logic            a_valid, a_sync, a_last, a_resync;
  logic [OW_A-1:0] a_data;
  state_t          a_state;
  logic            b_valid, b_sync, b_last, b_resync;
  logic [OW_B-1:0] b_data;
  state_t          b_state;

  fft_power_avg #(.IWIDTH(IW), .LGSIZE(3), .LGAVG(1), .OWIDTH(OW_A)) dut_a (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_ce        (i_ce),
    .i_sync      (i_sync),
    .i_sample    (i_sample),
    .o_valid     (a_valid),
    .o_data      (a_data),
    .o_sync      (a_sync),
    .o_last      (a_last),
    .o_resync    (a_resync),
    .o_dbg_state (a_state)
  );

  fft_power_avg #(.IWIDTH(IW), .LGSIZE(3), .LGAVG(0), .OWIDTH(OW_B)) dut_b (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_ce        (i_ce && ce_b_en),
    .i_sync      (i_sync),
    .i_sample    (i_sample),
    .o_valid     (b_valid),
    .o_data      (b_data),
    .o_sync      (b_sync),
    .o_last      (b_last),
    .o_resync    (b_resync),
    .o_dbg_state (b_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [OW_A+1:0] exp_q[$];     // {sync, last, data}
  logic [OW_B+1:0] exp_b_q[$];
  int unsigned     lat_q[$];     // cycle at which each dut_a word is due
  int resync_seen = 0;
  int valid_seen  = 0;
  logic [OW_A+1:0] ea;
  logic [OW_B+1:0] eb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_a(input logic [OW_A-1:0] d, input bit s, input bit l);
    exp_q.push_back({s, l, d});
  endtask

  task automatic push_b(input logic [OW_B-1:0] d, input bit s, input bit l);
    exp_b_q.push_back({s, l, d});
  endtask

  always @(negedge i_clk) begin
    if (a_resync) resync_seen++;
    if (a_valid) begin
      valid_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected: got data 0x%0h sync %0b last %0b, required no output (cycle %0d)",
                 a_data, a_sync, a_last, cyc);
      end else begin
        ea = exp_q.pop_front();
        check("a_data", 64'(a_data), 64'(ea[OW_A-1:0]));
        check("a_sync", 64'(a_sync), 64'(ea[OW_A+1]));
        check("a_last", 64'(a_last), 64'(ea[OW_A]));
        if (lat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_latency: got output at cycle %0d, required no pending sample", cyc);
        end else begin
          check("a_latency", 64'(cyc), 64'(lat_q.pop_front()));
        end
      end
    end else begin
      check("a_markers_idle", {62'd0, a_sync, a_last}, 64'd0);
    end
    if (b_valid) begin
      if (exp_b_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: got data 0x%0h, required no output (cycle %0d)", b_data, cyc);
      end else begin
        eb = exp_b_q.pop_front();
        check("b_data", 64'(b_data), 64'(eb[OW_B-1:0]));
        check("b_sync", 64'(b_sync), 64'(eb[OW_B+1]));
        check("b_last", 64'(b_last), 64'(eb[OW_B]));
      end
    end else begin
      check("b_markers_idle", {62'd0, b_sync, b_last}, 64'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int re, input int im, input bit sync, input bit lat);
    @(negedge i_clk);
    i_ce     = 1'b1;
    i_sync   = sync;
    i_sample = {re[15:0], im[15:0]};
    if (lat) lat_q.push_back(cyc + 3);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge i_clk);
      i_ce   = 1'b0;
      i_sync = 1'b0;
    end
  endtask

  task automatic drained(input string name);
    idle(6);
    check({name, "_a_queue_empty"}, 64'(exp_q.size()), 64'd0);
    check({name, "_lat_queue_empty"}, 64'(lat_q.size()), 64'd0);
    check({name, "_b_queue_empty"}, 64'(exp_b_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  int t3_exp[8] = '{0, 2, 8, 18, 32, 50, 72, 98};      // 2*b^2
  int t4_exp[8] = '{0, 2, 10, 22, 40, 62, 90, 122};    // floor((b^2 + 4b^2)/2)
  int t5_exp[8] = '{0, 1, 4, 9, 16, 25, 36, 49};       // b^2
  int v0;

  initial begin
    i_reset  = 1'b1;
    i_ce     = 1'b0;
    i_sync   = 1'b0;
    i_sample = '0;
    ce_b_en  = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_valid", 64'(a_valid), 64'd0);
    check("rst_data", 64'(a_data), 64'd0);
    check("rst_sync", 64'(a_sync), 64'd0);
    check("rst_last", 64'(a_last), 64'd0);
    check("rst_resync", 64'(a_resync), 64'd0);
    check("rst_state", 64'(a_state), 64'(ST_IDLE));
    check("rst_b_data", 64'(b_data), 64'd0);
    i_reset = 1'b0;

    // Samples without a sync are ignored.
    v0 = valid_seen;
    for (int i = 0; i < 20; i++) send(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 1'b0, 1'b0);
    idle(5);
    check("nosync_valid_count", 64'(valid_seen - v0), 64'd0);
    check("nosync_state", 64'(a_state), 64'(ST_IDLE));

    // re=3, im=4 -> 25 in every bin
    for (int b = 0; b < 8; b++) push_a(32'd25, b == 0, b == 7);
    for (int f = 0; f < 2; f++)
      for (int b = 0; b < 8; b++) send(3, 4, b == 0, f == 1);
    drained("t1");
    check("t1_state", 64'(a_state), 64'(ST_ACCUM));

    // Full-scale negative: P = 2^31. dut_a averages to 0x80000000,
    // dut_b (31-bit, no averaging) saturates to 0x7FFFFFFF every frame.
    ce_b_en = 1'b1;
    for (int b = 0; b < 8; b++) push_a(32'h8000_0000, b == 0, b == 7);
    for (int f = 0; f < 2; f++)
      for (int b = 0; b < 8; b++) push_b(31'h7FFF_FFFF, b == 0, b == 7);
    for (int f = 0; f < 2; f++)
      for (int b = 0; b < 8; b++) send(-32768, -32768, b == 0, f == 1);
    idle(1);
    ce_b_en = 1'b0;
    drained("t2");

    // re=bin, im=-bin -> 2*bin^2, gapless and then with random ce gaps
    for (int run = 0; run < 2; run++) begin
      for (int b = 0; b < 8; b++) push_a(32'(t3_exp[b]), b == 0, b == 7);
      for (int f = 0; f < 2; f++)
        for (int b = 0; b < 8; b++) begin
          send(b, -b, b == 0, f == 1);
          if (run == 1) idle(int'($urandom_range(0, 2)));
        end
      drained(run == 0 ? "t3_gapless" : "t3_gapped");
    end

    // Mid-frame resync at bin 5: earlier partial data must not leak.
    for (int b = 0; b < 8; b++) push_a(32'(t4_exp[b]), b == 0, b == 7);
    for (int b = 0; b < 5; b++) send(100, 0, b == 0, 1'b0);
    send(0, 0, 1'b1, 1'b0);
    idle(1);
    check("t4_resync_pulse", 64'(a_resync), 64'd1);
    idle(1);
    check("t4_resync_single", 64'(a_resync), 64'd0);
    for (int b = 1; b < 8; b++) send(b, 0, 1'b0, 1'b0);
    for (int b = 0; b < 8; b++) send(2 * b, 0, b == 0, 1'b1);
    drained("t4");
    check("t4_resync_count", 64'(resync_seen), 64'd1);

    // Reset during the output frame: in-flight words are dropped.
    for (int b = 0; b < 8; b++) send(50, 0, b == 0, 1'b0);
    send(50, 0, 1'b1, 1'b0);
    send(50, 0, 1'b0, 1'b0);
    @(negedge i_clk);
    i_ce    = 1'b0;
    i_sync  = 1'b0;
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    check("t5_rst_valid", 64'(a_valid), 64'd0);
    check("t5_rst_state", 64'(a_state), 64'(ST_IDLE));
    i_reset = 1'b0;
    for (int b = 0; b < 8; b++) push_a(32'(t5_exp[b]), b == 0, b == 7);
    for (int f = 0; f < 2; f++)
      for (int b = 0; b < 8; b++) send(0, b, b == 0, f == 1);
    drained("t5");

    check("final_resync_count", 64'(resync_seen), 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
